hit_input_frontend: RTL
=======================

Name: hit_input_frontend

Overview:
- Player-side front end for the tennis game state machine. It produces the `hits[1:0]` inputs the game consumes and the game-step tick.
- Raw push-buttons are synchronized, debounced and rising-edge detected. Each press is latched and then presented as a clean one-press-per-step `hits` vector that is stable for a whole game step.
- An internal programmable divider generates the game-step tick. Its period is driven by the game's `clkspeed` output.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable clock cycles required to accept a button level change (10 ms at 100 MHz); must be >= 1
PERIOD_W, 28, width of the period input and the tick counter
MIN_PERIOD, 2, smallest effective tick period; smaller programmed values are clamped up to this

Ports:
- clock  input  1  system clock
- reset_n  input  1  synchronous, active-low reset
- btn  input  2  raw asynchronous buttons; [1] = player 1, [0] = player 0; active-high
- period  input  PERIOD_W  game-step length in clock cycles (connected to the game's clkspeed)
- tick  output  1  one-cycle pulse marking a game-step boundary
- hits  output  2  per-player press flags, registered at tick and held until the next tick
- btn_stable  output  2  debounced button levels (debug / LED)

Behaviour:

Reset:
- Reset applies when reset_n is low at a clock edge. It is synchronous only, with no asynchronous path.
- On reset: synchronizer flops = 0, btn_stable = 00, debounce counters = 0, pending = 00, tick counter = 0, tick = 0, hits = 00.
- Reset mid-operation discards any pending presses and restarts the tick phase.

Synchronizer:
- 2-flop synchronizer per button. Its output is sync[i].

Debounce (per button, independent):
- When sync[i] == btn_stable[i], the counter is cleared.
- Otherwise the counter increments.
- When the counter reaches DEBOUNCE_CYCLES-1 while still mismatched, btn_stable[i] takes sync[i] on that edge and the counter clears.
- Any single-cycle return to the stable level restarts the count.
- A button held through reset release is seen as a new press once debounced. This is intended.

Press detect:
- press[i] = btn_stable[i] rising, from the registered previous value.
- press[i] sets pending[i], which is sticky.
- Multiple presses within one step collapse to a single flag.
- Release and re-press is required for another press because detection is edge-based.

Latency:
- Clean btn edge to pending set = DEBOUNCE_CYCLES + 3 cycles (2 sync + debounce + edge register).

Tick generator:
- eff_period = max(period, MIN_PERIOD).
- cnt increments every cycle.
- When cnt >= eff_period-1: tick = 1 for that cycle and cnt returns to 0. Otherwise tick = 0.
- The >= comparison handles period shrinking mid-count: tick fires on the next cycle, then runs at the new period.
- A period increase mid-count simply extends the current step.
- tick is a registered output, asserted the cycle after cnt reaches the terminal value.

Hits update (on the edge where the tick condition is true):
- hits <= pending | press. A press in the same cycle as the tick is included, not deferred.
- pending <= 00 in that same cycle.
- hits only changes on tick edges and is otherwise held.
- Both players may be flagged in the same step.

Widths and arithmetic:
- Tick counter is PERIOD_W bits.
- Debounce counter is clog2(DEBOUNCE_CYCLES+1) bits.
- No counter wraps in normal operation.

Test Plan (DEBOUNCE_CYCLES=4, MIN_PERIOD=2, period=10 unless stated):
1. Reset: reset_n low 3 cycles with btn=11.
   - Required: tick=0, hits=00 during reset.
   - After release: first tick pulse 10 cycles later, then every 10 cycles.
   - Both btn_stable bits go to 1 and hits=11 at the first tick at which pending is set.
2. Bounce: btn[0] toggles every 2 cycles for 12 cycles, then held 1.
   - Required: btn_stable[0] rises exactly once, DEBOUNCE_CYCLES+2 cycles after the final edge.
   - Required: exactly one tick with hits=01; the next tick gives hits=00.
3. Press on tick: btn[1] pressed so that press[1] coincides with the tick cycle.
   - Required: hits=10 at that tick, not the next; the following tick gives hits=00.
4. Period shrink: period changed 10 -> 4 while cnt=7.
   - Required: tick on the next cycle, then every 4 cycles.
5. Clamp: period=0, then period=1.
   - Required: tick every 2 cycles in both cases; no stuck or continuous tick.
6. Double press in one step: btn[0] pressed, released and pressed again (each clean), all within one tick window.
   - Required: hits=01 for one step only; pending cleared after that tick.

Source files
------------

// File: rtl/hit_input_frontend_if.sv
// Player input bus of the tennis front end: raw buttons and the step period
// go in; the step tick, latched hits and debounced levels come out.
interface hit_input_frontend_if #(
  parameter int PERIOD_W = 28
);
  logic [1:0]          btn;
  logic [PERIOD_W-1:0] period;
  logic                tick;
  logic [1:0]          hits;
  logic [1:0]          btn_stable;

  modport master (
    output btn, period,
    input  tick, hits, btn_stable
  );

  modport slave (
    input  btn, period,
    output tick, hits, btn_stable
  );
endinterface

// File: rtl/hit_input_frontend.sv
// Tennis player front end: synchronizes and debounces two push-buttons,
// detects presses, collects them per game step and emits the game-step tick
// from a programmable divider. Each step's hits vector is stable for the step.
module hit_input_frontend #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PERIOD_W        = 28,
  parameter int MIN_PERIOD      = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  hit_input_frontend_if.slave   bus
);

  localparam int                  DBW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DBW-1:0]      DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PERIOD_W-1:0] MIN_P   = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] ONE_P   = PERIOD_W'(1);

  logic [1:0]          sync_p0;
  logic [1:0]          sync_p1;
  logic [1:0]          stable_p2;
  logic [1:0]          stable_p3;
  logic [DBW-1:0]      db_cnt [2];
  logic [1:0]          pending;
  logic [1:0]          press;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] eff_period;
  logic                tick_cond;
  logic                tick_q;
  logic [1:0]          hits_q;

  // Stage p0/p1: two-flop synchronizer for the asynchronous buttons
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_p0 <= 2'b00;
      sync_p1 <= 2'b00;
    end else begin
      sync_p0 <= bus.btn;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: per-button debounce; a level is accepted only after it has
  // differed from the stable level for DEBOUNCE_CYCLES consecutive cycles
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stable_p2 <= 2'b00;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == stable_p2[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable_p2[i] <= sync_p1[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Stage p3: previous debounced level, used for rising-edge detection
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stable_p3 <= 2'b00;
    end else begin
      stable_p3 <= stable_p2;
    end
  end

  assign press = stable_p2 & ~stable_p3;

  // Programmed periods below MIN_PERIOD are clamped; >= lets a shrinking
  // period end the current step on the very next edge
  assign eff_period = (bus.period < MIN_P) ? MIN_P : bus.period;
  assign tick_cond  = (cnt >= (eff_period - ONE_P));

  // Step divider and hits latch; a press arriving on the tick edge goes
  // straight into this step's hits instead of being held for the next one
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt     <= '0;
      tick_q  <= 1'b0;
      hits_q  <= 2'b00;
      pending <= 2'b00;
    end else if (tick_cond) begin
      cnt     <= '0;
      tick_q  <= 1'b1;
      hits_q  <= pending | press;
      pending <= 2'b00;
    end else begin
      cnt     <= cnt + ONE_P;
      tick_q  <= 1'b0;
      pending <= pending | press;
    end
  end

  assign bus.tick       = tick_q;
  assign bus.hits       = hits_q;
  assign bus.btn_stable = stable_p2;

endmodule
